// File: rtl/traffic_conflict_monitor.sv
// Safety monitor for the four signal heads: checks every sampled light code against the
// previous sample and per-lane run lengths, latches the first fault and counts rotations.
module traffic_conflict_monitor #(
    parameter int MIN_YELLOW = 2,
    parameter int MAX_GREEN  = 20,
    parameter int CNT_W      = 8
) (
    input  logic       mclk,
    input  logic       rst,
    input  logic [1:0] r1,
    input  logic [1:0] r2,
    input  logic [1:0] r3,
    input  logic [1:0] r4,
    input  logic       fault_clr,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_lane,
    output logic       flash_req,
    output logic [7:0] rot_cnt
);

    localparam logic [1:0] ST_ARM = 2'd0;
    localparam logic [1:0] ST_MON = 2'd1;
    localparam logic [1:0] ST_FLT = 2'd2;

    localparam logic [1:0] C_RED = 2'b00;
    localparam logic [1:0] C_YEL = 2'b01;
    localparam logic [1:0] C_GRN = 2'b10;
    localparam logic [1:0] C_INV = 2'b11;

    localparam logic [CNT_W-1:0] MIN_Y_C   = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] MAX_G_C   = CNT_W'(MAX_GREEN);
    localparam logic [CNT_W-1:0] CNT_MAX_C = '1;
    localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       r_prev [4];
    logic [CNT_W-1:0] r_cnt  [4];
    logic             r_lg_valid;
    logic [1:0]       r_lg;

    logic [1:0]       w_cur      [4];
    logic [CNT_W-1:0] w_cnt_next [4];
    logic [3:0]       w_inv, w_act, w_seq, w_shy, w_stk, w_r2g, w_ord;
    logic             w_viol;
    logic [2:0]       w_code;
    logic [1:0]       w_lane;
    logic             w_rot_done;
    logic             w_all_red;

    assign w_cur[0] = r1;
    assign w_cur[1] = r2;
    assign w_cur[2] = r3;
    assign w_cur[3] = r4;

    function automatic logic [1:0] first_lane(input logic [3:0] v);
        first_lane = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) first_lane = 2'(i);
        end
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_inv[gi] = (w_cur[gi] == C_INV);
            assign w_act[gi] = (w_cur[gi] != C_RED);
            assign w_seq[gi] = ((r_prev[gi] == C_GRN) && (w_cur[gi] == C_RED)) ||
                               ((r_prev[gi] == C_RED) && (w_cur[gi] == C_YEL)) ||
                               ((r_prev[gi] == C_YEL) && (w_cur[gi] == C_GRN));
            assign w_shy[gi] = (r_prev[gi] == C_YEL) && (w_cur[gi] == C_RED) && (r_cnt[gi] < MIN_Y_C);
            assign w_stk[gi] = (r_prev[gi] == C_GRN) && (w_cur[gi] == C_GRN) && (r_cnt[gi] == MAX_G_C);
            assign w_r2g[gi] = (r_prev[gi] == C_RED) && (w_cur[gi] == C_GRN);
            // Only the lane after the last accepted green may turn green next.
            assign w_ord[gi] = w_r2g[gi] && r_lg_valid && (2'(gi) != (r_lg + 2'd1));
            assign w_cnt_next[gi] = (w_cur[gi] != r_prev[gi]) ? CNT_ONE_C :
                                    (r_cnt[gi] == CNT_MAX_C)  ? r_cnt[gi] : r_cnt[gi] + CNT_ONE_C;
        end
    endgenerate

    assign w_rot_done = (r_prev[3] == C_YEL) && (w_cur[3] == C_RED);
    assign w_all_red  = ~|w_act;

    always_comb begin
        w_viol = 1'b1;
        w_code = 3'd0;
        w_lane = 2'd0;
        if (|w_inv) begin
            w_code = 3'd1;
            w_lane = first_lane(w_inv);
        end else if ($countones(w_act) > 1) begin
            w_code = 3'd2;
            w_lane = first_lane(w_act);
        end else if (|w_seq) begin
            w_code = 3'd3;
            w_lane = first_lane(w_seq);
        end else if (|w_shy) begin
            w_code = 3'd4;
            w_lane = first_lane(w_shy);
        end else if (|w_stk) begin
            w_code = 3'd5;
            w_lane = first_lane(w_stk);
        end else if (|w_ord) begin
            w_code = 3'd6;
            w_lane = first_lane(w_ord);
        end else begin
            w_viol = 1'b0;
        end
    end

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_ARM;
            fault      <= 1'b0;
            flash_req  <= 1'b0;
            fault_code <= 3'd0;
            fault_lane <= 2'd0;
            rot_cnt    <= 8'd0;
            r_lg_valid <= 1'b0;
            r_lg       <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                r_prev[i] <= C_RED;
                r_cnt[i]  <= '0;
            end
        end else begin
            case (r_state)
                ST_ARM: begin
                    for (int i = 0; i < 4; i++) begin
                        r_prev[i] <= w_cur[i];
                        r_cnt[i]  <= CNT_ONE_C;
                    end
                    r_lg_valid <= 1'b0;
                    r_state    <= ST_MON;
                end
                ST_MON: begin
                    if (w_viol) begin
                        fault      <= 1'b1;
                        flash_req  <= 1'b1;
                        fault_code <= w_code;
                        fault_lane <= w_lane;
                        r_state    <= ST_FLT;
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            r_prev[i] <= w_cur[i];
                            r_cnt[i]  <= w_cnt_next[i];
                        end
                        // With no conflict at most one lane can be turning green.
                        if (|w_r2g) begin
                            r_lg_valid <= 1'b1;
                            r_lg       <= first_lane(w_r2g);
                        end
                        if (w_rot_done) rot_cnt <= rot_cnt + 8'd1;
                    end
                end
                ST_FLT: begin
                    if (fault_clr && w_all_red) begin
                        fault      <= 1'b0;
                        flash_req  <= 1'b0;
                        fault_code <= 3'd0;
                        fault_lane <= 2'd0;
                        r_state    <= ST_ARM;
                    end
                end
                default: r_state <= ST_ARM;
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed bench for traffic_conflict_monitor: a rule-level model is checked against the
// DUT on every falling edge, plus literal expectations at key points of each scenario.
module tb_traffic_conflict_monitor;

    localparam int MIN_YELLOW = 2;
    localparam int MAX_GREEN  = 20;

    logic       mclk = 1'b0;
    logic       rst  = 1'b0;
    logic [1:0] r1 = 2'b00, r2 = 2'b00, r3 = 2'b00, r4 = 2'b00;
    logic       fault_clr = 1'b0;
    logic       fault, flash_req;
    logic [2:0] fault_code;
    logic [1:0] fault_lane;
    logic [7:0] rot_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    traffic_conflict_monitor #(
        .MIN_YELLOW(MIN_YELLOW),
        .MAX_GREEN (MAX_GREEN),
        .CNT_W     (8)
    ) dut (
        .mclk      (mclk),
        .rst       (rst),
        .r1        (r1),
        .r2        (r2),
        .r3        (r3),
        .r4        (r4),
        .fault_clr (fault_clr),
        .fault     (fault),
        .fault_code(fault_code),
        .fault_lane(fault_lane),
        .flash_req (flash_req),
        .rot_cnt   (rot_cnt)
    );

    always #5 mclk = ~mclk;

    // Rule-level model: 0 arming, 1 monitoring, 2 faulted.
    int m_mode = 0;
    int m_prv[4] = '{0, 0, 0, 0};
    int m_run[4] = '{0, 0, 0, 0};
    int m_last = -1;
    int m_fault = 0, m_code = 0, m_lane = 0, m_rot = 0;

    function automatic bit legal_step(input int p, input int c);
        return (p == c) || (p == 0 && c == 2) || (p == 2 && c == 1) || (p == 1 && c == 0);
    endfunction

    function automatic void judge(input int cur[4], input int prv[4], input int run[4],
                                  input int last, output int code, output int lane);
        int n;
        code = 0;
        lane = 0;
        n = 0;
        for (int i = 3; i >= 0; i--) if (cur[i] == 3) begin code = 1; lane = i; end
        if (code == 0) begin
            for (int i = 3; i >= 0; i--) if (cur[i] != 0) begin n++; lane = i; end
            if (n >= 2) code = 2; else lane = 0;
        end
        if (code == 0)
            for (int i = 3; i >= 0; i--) if (!legal_step(prv[i], cur[i])) begin code = 3; lane = i; end
        if (code == 0)
            for (int i = 3; i >= 0; i--)
                if (prv[i] == 1 && cur[i] == 0 && run[i] < MIN_YELLOW) begin code = 4; lane = i; end
        if (code == 0)
            for (int i = 3; i >= 0; i--)
                if (prv[i] == 2 && cur[i] == 2 && run[i] == MAX_GREEN) begin code = 5; lane = i; end
        if (code == 0)
            for (int i = 3; i >= 0; i--)
                if (prv[i] == 0 && cur[i] == 2 && last >= 0 && i != (last + 1) % 4) begin code = 6; lane = i; end
    endfunction

    always @(posedge mclk or negedge rst) begin
        int cur[4];
        int code, lane;
        if (!rst) begin
            m_mode = 0; m_fault = 0; m_code = 0; m_lane = 0; m_rot = 0; m_last = -1;
            for (int i = 0; i < 4; i++) begin m_prv[i] = 0; m_run[i] = 0; end
        end else begin
            cur[0] = int'(r1); cur[1] = int'(r2); cur[2] = int'(r3); cur[3] = int'(r4);
            if (m_mode == 0) begin
                for (int i = 0; i < 4; i++) begin m_prv[i] = cur[i]; m_run[i] = 1; end
                m_last = -1;
                m_mode = 1;
            end else if (m_mode == 1) begin
                judge(cur, m_prv, m_run, m_last, code, lane);
                if (code != 0) begin
                    m_fault = 1; m_code = code; m_lane = lane; m_mode = 2;
                end else begin
                    for (int i = 0; i < 4; i++) begin
                        if (m_prv[i] == 0 && cur[i] == 2) m_last = i;
                        if (i == 3 && m_prv[i] == 1 && cur[i] == 0) m_rot = (m_rot + 1) % 256;
                        m_run[i] = (cur[i] == m_prv[i]) ? ((m_run[i] < 255) ? m_run[i] + 1 : 255) : 1;
                        m_prv[i] = cur[i];
                    end
                end
            end else begin
                if (fault_clr && cur[0] == 0 && cur[1] == 0 && cur[2] == 0 && cur[3] == 0) begin
                    m_fault = 0; m_code = 0; m_lane = 0; m_mode = 0;
                end
            end
        end
    end

    always @(negedge mclk) begin
        n_cmp++;
        if (fault !== 1'(m_fault) || flash_req !== 1'(m_fault) || fault_code !== 3'(m_code) ||
            fault_lane !== 2'(m_lane) || rot_cnt !== 8'(m_rot)) begin
            n_bad++;
            $display("FAIL model t=%0t got fault=%b flash=%b code=%0d lane=%0d rot=%0d want fault=%0d code=%0d lane=%0d rot=%0d",
                     $time, fault, flash_req, fault_code, fault_lane, rot_cnt, m_fault, m_code, m_lane, m_rot);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic step(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                        input logic [1:0] d, input logic clr);
        r1 = a; r2 = b; r3 = c; r4 = d; fault_clr = clr;
        @(posedge mclk);
        #2;
    endtask

    task automatic lane_cycle(input int lane, input int g, input int y);
        logic [1:0] v[4];
        for (int i = 0; i < 4; i++) v[i] = 2'b00;
        v[lane] = 2'b10;
        for (int k = 0; k < g; k++) step(v[0], v[1], v[2], v[3], 1'b0);
        v[lane] = 2'b01;
        for (int k = 0; k < y; k++) step(v[0], v[1], v[2], v[3], 1'b0);
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    endtask

    task automatic rotation(input int g, input int y);
        for (int l = 0; l < 4; l++) lane_cycle(l, g, y);
    endtask

    task automatic clear_fault();
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        step(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    endtask

    localparam logic [1:0] R = 2'b00, Y = 2'b01, G = 2'b10, X = 2'b11;

    initial begin
        repeat (2) @(posedge mclk);
        #2;
        chk("reset_fault", int'(fault), 0);
        chk("reset_code", int'(fault_code), 0);
        chk("reset_rot", int'(rot_cnt), 0);
        rst = 1'b1;
        step(R, R, R, R, 1'b0);

        rotation(5, 2);
        chk("rot_after_1", int'(rot_cnt), 1);
        rotation(5, 2);
        rotation(5, 2);
        chk("rot_after_3", int'(rot_cnt), 3);
        chk("legal_fault", int'(fault), 0);

        step(G, R, G, R, 1'b0);
        chk("conflict_fault", int'(fault), 1);
        chk("conflict_flash", int'(flash_req), 1);
        chk("conflict_code", int'(fault_code), 2);
        chk("conflict_lane", int'(fault_lane), 0);
        step(G, R, G, R, 1'b0);
        clear_fault();
        chk("cleared_fault", int'(fault), 0);

        step(R, G, R, R, 1'b0);
        step(R, R, R, R, 1'b0);
        chk("seq_code", int'(fault_code), 3);
        chk("seq_lane", int'(fault_lane), 1);
        clear_fault();
        step(R, G, R, R, 1'b0);
        step(R, Y, R, R, 1'b0);
        step(R, R, R, R, 1'b0);
        chk("shorty_code", int'(fault_code), 4);
        chk("shorty_lane", int'(fault_lane), 1);
        clear_fault();

        repeat (20) step(G, R, R, R, 1'b0);
        chk("green20_fault", int'(fault), 0);
        step(G, R, R, R, 1'b0);
        chk("stuck_code", int'(fault_code), 5);
        chk("stuck_lane", int'(fault_lane), 0);
        clear_fault();

        lane_cycle(0, 2, 2);
        step(R, R, G, R, 1'b0);
        chk("order_code", int'(fault_code), 6);
        chk("order_lane", int'(fault_lane), 2);
        step(R, R, G, R, 1'b1);
        chk("clr_ignored_fault", int'(fault), 1);
        chk("clr_ignored_code", int'(fault_code), 6);
        step(R, R, R, R, 1'b1);
        chk("clr_fault", int'(fault), 0);
        chk("clr_code", int'(fault_code), 0);
        step(R, R, R, R, 1'b0);
        step(G, R, R, R, 1'b0);
        chk("after_arm_fault", int'(fault), 0);

        step(G, G, R, X, 1'b0);
        chk("invalid_code", int'(fault_code), 1);
        chk("invalid_lane", int'(fault_lane), 3);
        #1 rst = 1'b0;
        #1;
        chk("async_fault", int'(fault), 0);
        chk("async_flash", int'(flash_req), 0);
        chk("async_code", int'(fault_code), 0);
        chk("async_lane", int'(fault_lane), 0);
        chk("async_rot", int'(rot_cnt), 0);
        r1 = R; r2 = R; r3 = R; r4 = R;
        @(posedge mclk);
        #2 rst = 1'b1;
        step(R, R, R, R, 1'b0);

        repeat (255) rotation(1, 2);
        chk("rot_255", int'(rot_cnt), 255);
        rotation(1, 2);
        chk("rot_wrap", int'(rot_cnt), 0);

        for (int l = 0; l < 3; l++) lane_cycle(l, 1, 2);
        lane_cycle(3, 1, 1);
        chk("simul_code", int'(fault_code), 4);
        chk("simul_lane", int'(fault_lane), 3);
        chk("simul_rot", int'(rot_cnt), 0);

        @(negedge mclk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
